byte_data_mem_hs: RTL

//  Parametrised byte-addressable data memory with a valid/ready request/response handshake and configurable access latency.

---
 rtl/byte_data_mem_hs.sv | 110 +++++++++++
 1 files changed

// File: rtl/byte_data_mem_hs.sv
// byte_data_mem_hs: byte-addressable RV32 data memory with valid/ready handshake and fixed access latency
module byte_data_mem_hs #(
  parameter int    ADDR_W    = 8,
  parameter int    DEPTH     = 256,
  parameter int    LAT       = 1,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t            state;
  logic [2:0]        cnt;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [7:0]        mem [DEPTH];
  logic              fire, commit, a_we, a_err, bad_f3, misal, oor;
  logic [2:0]        a_f3;
  logic [ADDR_W-1:0] a;
  logic [31:0]       a_wd, ld;
  logic [IW-1:0]     i0, i1, i2, i3;
  logic [7:0]        b0, b1, b2, b3;
  always_comb begin
    fire   = req_valid && req_ready;
    commit = (LAT == 1) ? state == IDLE && fire : state == WAIT && cnt == 3'd0;
    a_we   = state == IDLE ? req_we : r_we;
    a_f3   = state == IDLE ? req_funct3 : r_f3;
    a      = state == IDLE ? req_addr : r_addr;
    a_wd   = state == IDLE ? req_wdata : r_wdata;
    bad_f3 = a_we ? a_f3[2] || a_f3[1:0] == 2'b11
                  : a_f3[1:0] == 2'b11 || a_f3[2:1] == 2'b11;
    misal  = (a_f3[1:0] == 2'b01 && a[0]) || (a_f3[1:0] == 2'b10 && a[1:0] != 2'b00);
    oor    = 32'(a) >= DEPTH;
    a_err  = bad_f3 || misal || oor;
    i0     = a[IW-1:0];
    i1     = i0 | IW'(1);
    i2     = i0 | IW'(2);
    i3     = i0 | IW'(3);
    b0     = mem[i0];
    b1     = mem[i1];
    b2     = mem[i2];
    b3     = mem[i3];
    ld     = a_f3[1:0] == 2'b00 ? {{24{~a_f3[2] & b0[7]}}, b0}
           : a_f3[1:0] == 2'b01 ? {{16{~a_f3[2] & b1[7]}}, b1, b0}
           : {b3, b2, b1, b0};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      r_we      <= 1'b0;
      r_f3      <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      if (commit) begin
        state     <= RESP;
        req_ready <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_err   <= a_err;
        rsp_rdata <= (a_err || a_we) ? '0 : ld;
        if (a_we && !a_err) begin
          mem[i0] <= a_wd[7:0];
          if (a_f3[1:0] != 2'b00) mem[i1] <= a_wd[15:8];
          if (a_f3[1:0] == 2'b10) begin
            mem[i2] <= a_wd[23:16];
            mem[i3] <= a_wd[31:24];
          end
        end
      end
      case (state)
        IDLE: if (fire) begin
          r_we      <= req_we;
          r_f3      <= req_funct3;
          r_addr    <= req_addr;
          r_wdata   <= req_wdata;
          req_ready <= 1'b0;
          if (LAT != 1) begin
            state <= WAIT;
            cnt   <= 3'(LAT - 2);
          end
        end
        WAIT: if (cnt != 3'd0) cnt <= cnt - 3'd1;
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
